// File: rtl/tt_sweep_capture_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encodings and a
// constant-evaluable ceil(log2) used to size the dwell counter.
package tt_sweep_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tt_sweep_capture_dwell_counter.sv
// Per-vector dwell timer: counts 0..DWELL-1 while enabled and wraps, flagging
// the final dwell cycle so the sweeper knows when to sample f.
module dwell_counter
    import tt_sweep_capture_pkg::*;
#(
    parameter int DWELL = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = clog2(DWELL);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(DWELL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Self-timed truth-table sweeper: steps vec through every input code, samples
// the lab block's f at the end of each dwell window and compares the table.
//
//  state | meaning
//  IDLE  | vec parked at 0, waiting for start
//  APPLY | vec=idx held for DWELL clocks, f captured on the last one
//  DONE  | one-cycle completion: done pulses, match reflects full table
module tt_sweep_capture
    import tt_sweep_capture_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DWELL = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        vec,
    input  logic                   f,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [(1<<N_IN)-1:0]   result,
    output logic                   busy,
    output logic                   done,
    output logic                   match,
    output logic                   aborted
);

    localparam int TBL = 1 << N_IN;

    sweep_state_t    state, state_nxt;
    logic [N_IN-1:0] idx, idx_nxt;
    logic [TBL-1:0]  result_capt;
    logic [1:0]      rst_sync;
    logic            rst_int_n;
    logic            go, capture, kill, last_vec, dwell_last;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_int_n),
        .clr   (go),
        .en    (state == ST_APPLY),
        .last  (dwell_last)
    );

    assign last_vec = (idx == N_IN'(TBL - 1));

    always_comb begin
        result_capt      = result;
        result_capt[idx] = f;
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        capture   = 1'b0;
        kill      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_APPLY;
                    go        = 1'b1;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    kill      = 1'b1;
                end else if (dwell_last) begin
                    capture = 1'b1;
                    if (last_vec) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_nxt = idx;
        if (go) begin
            idx_nxt = '0;
        end else if (capture && !last_vec) begin
            idx_nxt = idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            vec     <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            match   <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            vec     <= (state_nxt == ST_APPLY) ? idx_nxt : '0;
            busy    <= (state_nxt == ST_APPLY);
            done    <= 1'b0;
            aborted <= kill;
            if (go) begin
                result <= '0;
                match  <= 1'b0;
            end
            // Final compare uses the table including the bit captured this edge.
            if (capture) begin
                result <= result_capt;
                if (last_vec) begin
                    done  <= 1'b1;
                    match <= (result_capt == expected);
                end
            end
            if (kill) begin
                match <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Directed bench for tt_sweep_capture (N_IN=3, DWELL=4): table of full sweeps
// plus hand sequences for abort, held start and mid-sweep reset.
module tb_tt_sweep_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       xnor_mode = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [2:0] vec;
    logic       f;
    logic [7:0] result;
    logic       busy, done, match, aborted;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign f = xnor_mode ? ~(^vec) : (^vec);

    tt_sweep_capture #(.N_IN(3), .DWELL(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .vec      (vec),
        .f        (f),
        .expected (expected),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .match    (match),
        .aborted  (aborted)
    );

    typedef struct {
        logic       xnor_mode;
        logic [7:0] expected;
        logic [7:0] exp_result;
        logic       exp_match;
    } sweep_vec_t;

    sweep_vec_t runs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called just after edge E0; checks every cycle up to and including DONE.
    task automatic sweep_check(input string tag, input logic [7:0] exp_res, input logic exp_m);
        for (int t = 0; t <= 32; t++) begin
            @(negedge clk);
            chk($sformatf("%s vec t=%0d", tag, t), {29'd0, vec}, (t < 32) ? t / 4 : 0);
            chk($sformatf("%s busy t=%0d", tag, t), {31'd0, busy}, (t < 32) ? 1 : 0);
            chk($sformatf("%s done t=%0d", tag, t), {31'd0, done}, (t == 32) ? 1 : 0);
            chk($sformatf("%s aborted t=%0d", tag, t), {31'd0, aborted}, 0);
        end
        chk({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
        chk({tag, " match"}, {31'd0, match}, {31'd0, exp_m});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " vec"}, {29'd0, vec}, 0);
        chk({tag, " result"}, {24'd0, result}, 0);
        chk({tag, " busy"}, {31'd0, busy}, 0);
        chk({tag, " done"}, {31'd0, done}, 0);
        chk({tag, " match"}, {31'd0, match}, 0);
        chk({tag, " aborted"}, {31'd0, aborted}, 0);
    endtask

    initial begin
        runs[0] = '{1'b0, 8'h96, 8'h96, 1'b1};
        runs[1] = '{1'b0, 8'h97, 8'h96, 1'b0};
        runs[2] = '{1'b1, 8'h69, 8'h69, 1'b1};
        runs[3] = '{1'b1, 8'h96, 8'h69, 1'b0};

        #2;
        chk_all_zero("reset");
        #20;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_all_zero("post-reset");

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            xnor_mode = runs[i].xnor_mode;
            expected  = runs[i].expected;
            launch();
            sweep_check($sformatf("run%0d", i), runs[i].exp_result, runs[i].exp_match);
            @(negedge clk);
            chk($sformatf("run%0d done after", i), {31'd0, done}, 0);
            chk($sformatf("run%0d busy after", i), {31'd0, busy}, 0);
            chk($sformatf("run%0d result held", i), {24'd0, result}, {24'd0, runs[i].exp_result});
            chk($sformatf("run%0d match held", i), {31'd0, match}, {31'd0, runs[i].exp_match});
        end

        // start together with abort in IDLE: nothing happens
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("idle start+abort busy", {31'd0, busy}, 0);
        chk("idle start+abort aborted", {31'd0, aborted}, 0);

        // abort while vec==3
        xnor_mode = 1'b0;
        expected  = 8'h96;
        launch();
        repeat (14) @(negedge clk);
        chk("abort pre vec", {29'd0, vec}, 3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort vec", {29'd0, vec}, 0);
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort pulse", {31'd0, aborted}, 1);
        chk("abort result", {24'd0, result}, 32'h06);
        chk("abort match", {31'd0, match}, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("abort after%0d done", k), {31'd0, done}, 0);
            chk($sformatf("abort after%0d aborted", k), {31'd0, aborted}, 0);
            chk($sformatf("abort after%0d result", k), {24'd0, result}, 32'h06);
        end

        // abort during DONE is ignored
        launch();
        sweep_check("done-abort", 8'h96, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("done-abort aborted", {31'd0, aborted}, 0);
        chk("done-abort match", {31'd0, match}, 1);
        chk("done-abort result", {24'd0, result}, 32'h96);

        // start held through the sweep plus two clocks
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        sweep_check("held1", 8'h96, 1'b1);
        @(negedge clk);
        chk("held idle busy", {31'd0, busy}, 0);
        chk("held idle vec", {29'd0, vec}, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        sweep_check("held2", 8'h96, 1'b1);

        // asynchronous reset mid-sweep at vec==5
        xnor_mode = 1'b1;
        expected  = 8'h69;
        launch();
        repeat (22) @(negedge clk);
        chk("rst pre vec", {29'd0, vec}, 5);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async rst");
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_all_zero("after rst");
        launch();
        sweep_check("post-rst", 8'h69, 1'b1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
